// File: rtl/mem_bus_ctrl_pkg.sv
// mem_bus_ctrl_pkg: shared size codes, FSM states, timeout limit and helpers for the data-bus controller
package mem_bus_ctrl_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUS  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam logic [7:0]  TIMEOUT_LIM = 8'd255;
    localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;

    // Reserved sizes and accesses not on their natural boundary never reach the bus
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        return (size == SZ_HALF && off[0]) || (size == SZ_WORD && off != 2'b00) || size == SZ_RSVD;
    endfunction

endpackage

// File: rtl/mem_bus_ctrl_lane_fmt.sv
// mem_lane_fmt: big-endian byte-lane select, store replication and load extension
module mem_lane_fmt
    import mem_bus_ctrl_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  sel,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Offset 0 is the most significant lane; the picked lane is right-justified and extended
    always_comb begin
        lane_b    = off == 2'd0 ? rdata[31:24] : off == 2'd1 ? rdata[23:16] : off == 2'd2 ? rdata[15:8] : rdata[7:0];
        lane_h    = off[1] ? rdata[15:0] : rdata[31:16];
        sel       = size == SZ_BYTE ? 4'b1000 >> off : size == SZ_HALF ? (off[1] ? 4'b0011 : 4'b1100) : 4'b1111;
        wdata_rep = size == SZ_BYTE ? {4{wdata[7:0]}} : size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
        rdata_ext = size == SZ_BYTE ? {{24{sign & lane_b[7]}}, lane_b}
                  : size == SZ_HALF ? {{16{sign & lane_h[15]}}, lane_h} : rdata;
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: MEM-stage load/store to data-bus controller with alignment check, timeout and flush kill
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [1:0]  mem_size_i,
    input  logic        mem_sign_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic        flush_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    output logic        stall_req_o,
    output logic [31:0] rdata_o,
    output logic        done_o,
    output logic        align_err_o,
    output logic        bus_err_o
);

    state_e      state, nxt;
    logic        we_q, sign_q, kill_q, aerr_q, terr_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q;
    logic [7:0]  cnt_q;
    logic [3:0]  sel;
    logic [31:0] wdata_rep, rdata_ext;
    logic        in_bus, in_done, accept, mis, tmo, drop;

    assign in_bus  = state == ST_BUS;
    assign in_done = state == ST_DONE;
    assign accept  = state == ST_IDLE && mem_req_i && !flush_i;
    assign mis     = misaligned(mem_size_i, mem_addr_i[1:0]);
    assign tmo     = in_bus && !bus_ack_i && (cnt_q + 8'd1) == TIMEOUT_LIM;
    assign drop    = kill_q || flush_i;

    mem_lane_fmt u_fmt (
        .size      (size_q),
        .sign      (sign_q),
        .off       (addr_q[1:0]),
        .wdata     (wdata_q),
        .rdata     (bus_rdata_i),
        .sel       (sel),
        .wdata_rep (wdata_rep),
        .rdata_ext (rdata_ext)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= nxt;
    end

    // Next state and bus/status outputs; bus lanes are only driven while the transfer is open
    always_comb begin
        nxt = state == ST_IDLE ? (accept ? (mis ? ST_DONE : ST_BUS) : ST_IDLE)
            : state == ST_BUS  ? ((bus_ack_i || tmo) ? ST_DONE : ST_BUS) : ST_IDLE;
        bus_req_o   = in_bus;
        bus_we_o    = in_bus && we_q;
        bus_sel_o   = in_bus ? sel : 4'b0000;
        bus_addr_o  = {addr_q[31:2], 2'b00};
        bus_wdata_o = wdata_rep;
        stall_req_o = !rst && (accept || in_bus);
        done_o      = in_done && !kill_q && !aerr_q && !terr_q;
        align_err_o = in_done && aerr_q;
        bus_err_o   = in_done && terr_q && !kill_q;
    end

    // Request capture, timeout counting, kill tracking and load result update
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            sign_q  <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= ZERO_WORD;
            wdata_q <= ZERO_WORD;
            cnt_q   <= 8'd0;
            kill_q  <= 1'b0;
            aerr_q  <= 1'b0;
            terr_q  <= 1'b0;
            rdata_o <= ZERO_WORD;
        end else begin
            if (accept) begin
                we_q    <= mem_we_i;
                sign_q  <= mem_sign_i;
                size_q  <= mem_size_i;
                addr_q  <= mem_addr_i;
                wdata_q <= mem_wdata_i;
                cnt_q   <= 8'd0;
                kill_q  <= 1'b0;
                aerr_q  <= mis;
                terr_q  <= 1'b0;
            end
            if (in_bus) begin
                if (!bus_ack_i) cnt_q <= cnt_q + 8'd1;
                kill_q <= drop;
                terr_q <= tmo;
                if (bus_ack_i && !we_q && !drop) rdata_o <= rdata_ext;
                if (tmo && !drop) rdata_o <= ZERO_WORD;
            end
        end
    end

endmodule

// File: doc/mem_bus_ctrl.md
MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 SHALL have these ports; clock and reset first:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- mem_req_i  in  1  MEM stage has a load/store this cycle
- mem_we_i  in  1  1 = store, 0 = load
- mem_size_i  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved
- mem_sign_i  in  1  sign-extend load result
- mem_addr_i  in  32  byte address
- mem_wdata_i  in  32  store data, right-justified
- flush_i  in  1  pipeline flush
- bus_req_o  out  1  data-bus request
- bus_we_o  out  1  data-bus write
- bus_addr_o  out  32  word-aligned address, bits [1:0] = 00
- bus_sel_o  out  4  byte lane enables
- bus_wdata_o  out  32  lane-replicated store data
- bus_ack_i  in  1  bus completes the transfer this cycle
- bus_rdata_i  in  32  read data, valid with bus_ack_i
- stall_req_o  out  1  hold the pipeline
- rdata_o  out  32  extended load result, held until next access
- done_o  out  1  one-cycle completion pulse
- align_err_o  out  1  one-cycle misalignment pulse
- bus_err_o  out  1  one-cycle timeout pulse

Function
REQ-002 SHALL implement FSM IDLE -> BUS -> DONE -> IDLE; IDLE -> DONE directly on misalignment.
REQ-003 IDLE: mem_req_i=1 and flush_i=0 SHALL register we/size/sign/addr/wdata; aligned -> BUS, misaligned -> DONE with an error flag.
REQ-004 Misaligned SHALL mean: half with addr[0]=1, word with addr[1:0]!=00, or size=11; no bus cycle is issued.
REQ-005 stall_req_o SHALL be combinational: (IDLE and mem_req_i and not flush_i) or state==BUS; it SHALL be 0 in DONE.
REQ-006 BUS: bus_req_o=1; bus_addr_o, bus_we_o, bus_sel_o and bus_wdata_o SHALL stay stable until the cycle bus_ack_i=1 is sampled.
REQ-007 Lane mapping SHALL be big-endian:
- byte offset 0..3 -> sel 1000/0100/0010/0001, data [31:24]..[7:0]
- half offset 0/2 -> sel 1100/0011
- word -> sel 1111
REQ-008 Store data SHALL be replicated: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word unchanged.
REQ-009 Load data SHALL take the selected lane, right-justified; sign-extend if sign=1, else zero-extend; captured into rdata_o on ack.
REQ-010 BUS -> DONE on bus_ack_i; done_o=1 in DONE.
REQ-011 Timeout: an 8-bit counter SHALL clear on BUS entry and increment each BUS cycle without ack. At 255 without ack:
- drop bus_req_o and go to DONE
- bus_err_o=1 in DONE, done_o=0, rdata_o=0
REQ-012 Misalignment path: align_err_o=1 in DONE, done_o=0, rdata_o unchanged.
REQ-013 flush_i in BUS SHALL NOT abort the bus transfer; it sets a kill flag, and done_o, bus_err_o and the rdata_o update are suppressed in DONE.
REQ-014 DONE SHALL last exactly one cycle and ignore mem_req_i; the next access is accepted in the following IDLE cycle.
REQ-015 Latency SHALL be: request cycle 0, bus_req_o from cycle 1, ack in cycle k>=1, done_o in cycle k+1.
REQ-016 bus_ack_i outside BUS SHALL be ignored.

Reset
REQ-017 rst=1 at a clock edge SHALL set:
- state IDLE, counter 0, kill flag 0
- bus_req_o, bus_we_o, done_o, align_err_o, bus_err_o = 0
- bus_addr_o, bus_sel_o, bus_wdata_o, rdata_o = 0
REQ-018 Reset mid-BUS SHALL drop bus_req_o from the next cycle; a later ack SHALL be ignored.
REQ-019 While rst=1, stall_req_o SHALL be 0.

Structure
REQ-020 Size codes, FSM state encodings, timeout limit (255) and ZeroWord SHALL live in the shared defines include.
REQ-021 Lane select/extend logic SHALL be a combinational sub-module, mem_lane_fmt; FSM and registers stay in mem_bus_ctrl.

Verification
REQ-022 Bench SHALL cover:
- Word load, addr 0x100, ack on 2nd BUS cycle, rdata 0xDEADBEEF -> bus_sel 1111, addr 0x100, rdata_o 0xDEADBEEF, done_o at cycle 3, stall 0..2.
- Signed byte load, addr 0x103, rdata 0x000000F0 -> sel 0001, rdata_o 0xFFFFFFF0; unsigned -> 0x000000F0.
- Half store, addr 0x202, wdata 0x1234ABCD -> bus_we 1, sel 0011, bus_wdata 0xABCDABCD, addr 0x200.
- Word load, addr 0x101 -> no bus_req_o, align_err_o pulse in cycle 1, stall only in cycle 0.
- No ack for 255 BUS cycles -> bus_req_o drops, bus_err_o pulse, rdata_o 0.
- flush_i in BUS, then ack -> no done_o, rdata_o unchanged; separately, rst mid-BUS -> bus_req_o 0 next cycle.
